// File: rtl/bus_sram_slave.sv
// Word-addressed, byte-writable single-port SRAM responder for the core memory bus,
// with a fixed wait-state count. Define BUS_SRAM_FAULT_EN to add the sticky miss fault outputs.
module bus_sram_slave #(
  parameter int          ADDR_BITS   = 12,
  parameter logic [29:0] BASE        = 30'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] bus_addr,
  input  logic        bus_start,
  input  logic        bus_write,
  input  logic [31:0] bus_data_wr,
  input  logic [3:0]  bus_data_be,
  output logic        bus_ready,
  output logic [31:0] bus_data_rd
`ifdef BUS_SRAM_FAULT_EN
  ,
  output logic        fault,
  output logic [29:0] fault_addr
`endif
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam bit         NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [3:0] CNT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt;
  logic [29:0] r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH];

  logic                 w_accept, w_enter_resp, w_from_wait, w_hit, w_mem_we;
  logic [29:0]          w_acc_addr;
  logic                 w_acc_write;
  logic [31:0]          w_acc_wdata;
  logic [3:0]           w_acc_be;
  logic [ADDR_BITS-1:0] w_idx;

  // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    unique case (r_state)
      S_IDLE, S_RESP: begin
        w_state_nxt = S_IDLE;
        if (bus_start) begin
          w_accept = 1'b1;
          if (NO_WAIT) begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // With no wait states the array is accessed on the accepting edge, before the latches hold the request.
  assign w_from_wait = (r_state == S_WAIT);
  assign w_acc_addr  = w_from_wait ? r_addr  : bus_addr;
  assign w_acc_write = w_from_wait ? r_write : bus_write;
  assign w_acc_wdata = w_from_wait ? r_wdata : bus_data_wr;
  assign w_acc_be    = w_from_wait ? r_be    : bus_data_be;

  assign w_hit    = (w_acc_addr[29:ADDR_BITS] == BASE[29:ADDR_BITS]);
  assign w_idx    = w_acc_addr[ADDR_BITS-1:0];
  assign w_mem_we = rst_n && w_enter_resp && w_acc_write && w_hit;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr  <= bus_addr;
        r_write <= bus_write;
        r_wdata <= bus_data_wr;
        r_be    <= bus_data_be;
        r_cnt   <= CNT_LOAD;
      end else if (w_from_wait && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp && !w_acc_write)
        r_rdata <= w_hit ? r_mem[w_idx] : 32'h0;
    end
  end

  // NOTE: the array has no reset; contents survive rst_n and power up undefined.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++)
        if (w_acc_be[b]) r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
    end
  end

  assign bus_ready   = (r_state == S_RESP);
  assign bus_data_rd = r_rdata;

`ifdef BUS_SRAM_FAULT_EN
  logic        r_fault;
  logic [29:0] r_fault_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_enter_resp && !w_hit) begin
      r_fault <= 1'b1;
      if (!r_fault) r_fault_addr <= w_acc_addr;
    end
  end

  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
`endif

endmodule

// File: tb/tb_bus_sram_slave.sv
// Directed bench for bus_sram_slave: three instances (1, 0 and 3 wait states) share one request bus;
// sel routes bus_start and the observed outputs to one instance at a time.
module tb_bus_sram_slave;

  localparam int          AB     = 4;
  localparam logic [29:0] BASE_A = 30'h40;

  logic        clk;
  logic        rst_n;
  logic [29:0] bus_addr;
  logic        bus_start;
  logic        bus_write;
  logic [31:0] bus_data_wr;
  logic [3:0]  bus_data_be;
  int          sel;

  logic        w_start1, w_start0, w_start3;
  logic        w_ready1, w_ready0, w_ready3, w_ready;
  logic [31:0] w_rdata1, w_rdata0, w_rdata3, w_rdata;

  int n_checks = 0;
  int n_errors = 0;

  assign w_start1 = bus_start && (sel == 0);
  assign w_start0 = bus_start && (sel == 1);
  assign w_start3 = bus_start && (sel == 2);

`ifdef BUS_SRAM_FAULT_EN
  logic        w_fault1, w_fault0, w_fault3;
  logic [29:0] w_faddr1, w_faddr0, w_faddr3;
`endif

  bus_sram_slave #(.ADDR_BITS(AB), .BASE(BASE_A), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_start(w_start1), .bus_write(bus_write),
    .bus_data_wr(bus_data_wr), .bus_data_be(bus_data_be), .bus_ready(w_ready1), .bus_data_rd(w_rdata1)
`ifdef BUS_SRAM_FAULT_EN
    , .fault(w_fault1), .fault_addr(w_faddr1)
`endif
  );

  bus_sram_slave #(.ADDR_BITS(AB), .BASE(BASE_A), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_start(w_start0), .bus_write(bus_write),
    .bus_data_wr(bus_data_wr), .bus_data_be(bus_data_be), .bus_ready(w_ready0), .bus_data_rd(w_rdata0)
`ifdef BUS_SRAM_FAULT_EN
    , .fault(w_fault0), .fault_addr(w_faddr0)
`endif
  );

  bus_sram_slave #(.ADDR_BITS(AB), .BASE(BASE_A), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_start(w_start3), .bus_write(bus_write),
    .bus_data_wr(bus_data_wr), .bus_data_be(bus_data_be), .bus_ready(w_ready3), .bus_data_rd(w_rdata3)
`ifdef BUS_SRAM_FAULT_EN
    , .fault(w_fault3), .fault_addr(w_faddr3)
`endif
  );

  always_comb begin
    w_ready = w_ready1;
    w_rdata = w_rdata1;
    case (sel)
      1:       begin w_ready = w_ready0; w_rdata = w_rdata0; end
      2:       begin w_ready = w_ready3; w_rdata = w_rdata3; end
      default: begin w_ready = w_ready1; w_rdata = w_rdata1; end
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, act, exp);
    end
  endtask

  function automatic int ws_of(input int s);
    return (s == 1) ? 0 : (s == 2) ? 3 : 1;
  endfunction

  // One isolated transaction: checks start-to-ready latency and the single-cycle ready pulse.
  task automatic txn(input int s, input logic wr, input logic [29:0] addr, input logic [31:0] data,
                     input logic [3:0] be, input string tag, output logic [31:0] rd);
    int n;
    sel = s;
    @(posedge clk); #1;
    bus_addr = addr; bus_write = wr; bus_data_wr = data; bus_data_be = be; bus_start = 1'b1;
    @(posedge clk); #1;
    bus_start = 1'b0; bus_addr = ~addr; bus_write = ~wr; bus_data_wr = ~data; bus_data_be = ~be;
    n = 1;
    while (!w_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(ws_of(s) + 1));
    rd = w_rdata;
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'b0, w_ready}, 32'h0);
  endtask

  logic [31:0] rd;
  logic [31:0] b2b_val [4];
  int n, extra;

  initial begin
    rst_n = 1'b1; sel = 0; bus_start = 1'b0; bus_write = 1'b0;
    bus_addr = '0; bus_data_wr = '0; bus_data_be = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready1", {31'b0, w_ready1}, 32'h0);
    check("rst_ready0", {31'b0, w_ready0}, 32'h0);
    check("rst_ready3", {31'b0, w_ready3}, 32'h0);
    check("rst_rdata1", w_rdata1, 32'h0);
    check("rst_rdata3", w_rdata3, 32'h0);
`ifdef BUS_SRAM_FAULT_EN
    check("rst_fault", {31'b0, w_fault1}, 32'h0);
    check("rst_fault_addr", {2'b0, w_faddr1}, 32'h0);
`endif
    rst_n = 1'b1;

    // One wait state: full-word write then read back.
    txn(0, 1'b1, BASE_A + 30'd5, 32'hDEADBEEF, 4'hF, "w5", rd);
    txn(0, 1'b0, BASE_A + 30'd5, 32'h0, 4'hF, "r5", rd);
    check("r5_data", rd, 32'hDEADBEEF);

    // Byte-lane merge, then a be=0000 no-op write that must not disturb data or bus_data_rd.
    txn(0, 1'b1, BASE_A + 30'd3, 32'h11223344, 4'hF, "w3_pre", rd);
    txn(0, 1'b1, BASE_A + 30'd3, 32'hAABBCCDD, 4'b0101, "w3_be", rd);
    txn(0, 1'b0, BASE_A + 30'd3, 32'h0, 4'hF, "r3", rd);
    check("r3_data", rd, 32'h11BB33DD);
    txn(0, 1'b1, BASE_A + 30'd3, 32'h99999999, 4'b0000, "w3_nop", rd);
    check("w3_nop_rdata_held", rd, 32'h11BB33DD);
    txn(0, 1'b0, BASE_A + 30'd3, 32'h0, 4'hF, "r3b", rd);
    check("r3b_data", rd, 32'h11BB33DD);

    // Miss: one past the window reads zero; a miss write aliasing entry 0 is dropped.
    txn(0, 1'b1, BASE_A, 32'h12345678, 4'hF, "w0_pre", rd);
    txn(0, 1'b0, BASE_A + 30'd16, 32'h0, 4'hF, "miss_rd", rd);
    check("miss_rd_data", rd, 32'h0);
`ifdef BUS_SRAM_FAULT_EN
    check("miss_fault", {31'b0, w_fault1}, 32'h1);
    check("miss_fault_addr", {2'b0, w_faddr1}, {2'b0, BASE_A + 30'd16});
`endif
    txn(0, 1'b1, BASE_A + 30'd16, 32'hFFFFFFFF, 4'hF, "miss_wr", rd);
    txn(0, 1'b0, BASE_A, 32'h0, 4'hF, "r0", rd);
    check("r0_after_miss_wr", rd, 32'h12345678);

    // Zero wait states: preload 4 words, then 4 back-to-back reads with a start in every RESP cycle.
    b2b_val[0] = 32'hA0A0_0001; b2b_val[1] = 32'hB1B1_0002;
    b2b_val[2] = 32'hC2C2_0003; b2b_val[3] = 32'hD3D3_0004;
    for (int i = 0; i < 4; i++)
      txn(1, 1'b1, BASE_A + 30'(i), b2b_val[i], 4'hF, $sformatf("b2b_pre%0d", i), rd);
    sel = 1;
    @(posedge clk); #1;
    bus_write = 1'b0; bus_data_be = 4'hF; bus_addr = BASE_A; bus_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_ready%0d", i), {31'b0, w_ready}, 32'h1);
      check($sformatf("b2b_data%0d", i), w_rdata, b2b_val[i]);
      if (i < 3) bus_addr = BASE_A + 30'(i + 1);
      else       bus_start = 1'b0;
    end
    @(posedge clk); #1;
    check("b2b_idle", {31'b0, w_ready}, 32'h0);

    // Three wait states: a start pulsed during WAIT with another address is ignored.
    txn(2, 1'b1, BASE_A + 30'd8, 32'hA5A5A5A5, 4'hF, "w8", rd);
    txn(2, 1'b1, BASE_A + 30'd9, 32'h5A5A5A5A, 4'hF, "w9", rd);
    sel = 2;
    @(posedge clk); #1;
    bus_write = 1'b0; bus_data_be = 4'hF; bus_addr = BASE_A + 30'd8; bus_start = 1'b1;
    @(posedge clk); #1;
    bus_addr = BASE_A + 30'd9;
    @(posedge clk); #1;
    bus_start = 1'b0;
    n = 2;
    while (!w_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_start_latency", 32'(n), 32'd4);
    check("wait_start_data", w_rdata, 32'hA5A5A5A5);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (w_ready) extra++;
    end
    check("wait_start_no_extra_ready", 32'(extra), 32'd0);

    // Reset during WAIT of a write: abandoned, no ready, and the word keeps its old value.
    txn(2, 1'b1, BASE_A + 30'd7, 32'h0, 4'hF, "w7_pre", rd);
    txn(2, 1'b0, BASE_A + 30'd8, 32'h0, 4'hF, "r8", rd);
    check("r8_data", rd, 32'hA5A5A5A5);
    sel = 2;
    @(posedge clk); #1;
    bus_write = 1'b1; bus_data_be = 4'hF; bus_addr = BASE_A + 30'd7; bus_data_wr = 32'hCAFEF00D;
    bus_start = 1'b1;
    @(posedge clk); #1;
    bus_start = 1'b0;
    rst_n = 1'b0;
    #2;
    check("mid_rst_ready", {31'b0, w_ready}, 32'h0);
    check("mid_rst_rdata", w_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (w_ready) extra++;
    end
    check("mid_rst_no_ready", 32'(extra), 32'd0);
    check("mid_rst_rdata_after", w_rdata, 32'h0);
`ifdef BUS_SRAM_FAULT_EN
    check("mid_rst_fault_cleared", {31'b0, w_fault1}, 32'h0);
`endif
    txn(2, 1'b0, BASE_A + 30'd7, 32'h0, 4'hF, "r7", rd);
    check("r7_data", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
